// File: rtl/regfile_wr_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default widths, the arbiter FSM state type and the index of the
// hard-wired zero register.
package regfile_wr_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 32;

  // Register 0 reads as zero and never takes a write.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WIPE = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wr_decode.sv
// Register index to one-hot write-enable decoder with register 0 suppressed.
// Latency: combinational.
// Backpressure: none; en gates the whole vector.
//
// Ports:
//   addr   - register index
//   en     - decode enable; all-zero output when low
//   onehot - one bit per register, bit REG_ZERO never set
module regfile_wr_decode
  import regfile_wr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    // Starting above REG_ZERO leaves the zero register permanently unwritten.
    for (int i = REG_ZERO + 1; i < NREGS; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Two-requester register-file write arbiter with a register wipe sequencer.
// Latency: 1 cycle from accepting edge to wr_en/wr_data; wipe covers regs 1..NREGS-1.
// Backpressure: ready is combinational from valid/state/pointer; both readies low while wiping or in clr.
//
// Ports:
//   clk, clr           - clock, synchronous active-high clear
//   a_valid/a_ready    - ALU writeback handshake, a_addr/a_data payload
//   b_valid/b_ready    - multdiv writeback handshake, b_addr/b_data payload
//   wipe_req           - pulse that starts zeroing every register
//   wipe_busy          - high while the wipe sequence is running
//   wr_en, wr_data     - registered one-hot enable and data to the register array
//
// Build option: define REGFILE_WR_ARB_RR_EN for round-robin arbitration;
// otherwise requester A has fixed priority and no pointer state exists.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wipe_req,
  output logic              wipe_busy,
  output logic [NREGS-1:0]  wr_en,
  output logic [DATA_W-1:0] wr_data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0]  wr_en_q;
  logic [DATA_W-1:0] wr_data_q, data_d;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic [NREGS-1:0]  dec_onehot;
  logic              prio_b;
  logic              idle_open;
  logic              grant_a, grant_b;

`ifdef REGFILE_WR_ARB_RR_EN
  // High when B should win the next contended cycle.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= 1'b0;
    end else if (a_ready) begin
      ptr_q <= 1'b1;
    end else if (b_ready) begin
      ptr_q <= 1'b0;
    end
  end

  assign prio_b = ptr_q;
`else
  assign prio_b = 1'b0;
`endif

  // A wipe request pre-empts any request presented in the same cycle.
  assign idle_open = (state_q == IDLE) && !clr && !wipe_req;
  assign grant_a   = a_valid && (!b_valid || !prio_b);
  assign grant_b   = b_valid && (!a_valid || prio_b);
  assign a_ready   = idle_open && grant_a;
  assign b_ready   = idle_open && grant_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dec_addr = '0;
    dec_en   = 1'b0;
    data_d   = '0;
    case (state_q)
      IDLE: begin
        if (wipe_req) begin
          state_d  = WIPE;
          cnt_d    = ADDR_W'(1);
          dec_addr = ADDR_W'(1);
          dec_en   = 1'b1;
        end else if (a_ready) begin
          dec_addr = a_addr;
          dec_en   = 1'b1;
          data_d   = a_data;
        end else if (b_ready) begin
          dec_addr = b_addr;
          dec_en   = 1'b1;
          data_d   = b_data;
        end
      end
      WIPE: begin
        // wipe_req is not looked at here, so a second pulse cannot restart.
        if (cnt_q == ADDR_W'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + ADDR_W'(1);
          dec_addr = cnt_q + ADDR_W'(1);
          dec_en   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One decoder serves both the request path and the wipe walk.
  regfile_wr_decode #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_decode (
    .addr   (dec_addr),
    .en     (dec_en),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= dec_onehot;
      wr_data_q <= data_d;
    end
  end

  assign wipe_busy = (state_q == WIPE);
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;

endmodule
